// File: rtl/line_track_steer.sv
// Registered line-tracking steering controller: sensor decode, timed pivots, lost-line search, stop.
// Optional TRACK_SYNC_EN: adds a 2-flop synchroniser on path_sens ahead of the decode.
module line_track_steer #(
   parameter int N_SENS     = 4,
   parameter int DUTY_W     = 8,
   parameter int SPD_FULL   = 255,
   parameter int SPD_SHARP  = 250,
   parameter int SPD_CURVE  = 220,
   parameter int SPD_EDGE   = 150,
   parameter int TURN_HOLD  = 80,
   parameter int LOST_DLY   = 16,
   parameter int SEARCH_MAX = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_tracing,
   input  logic [N_SENS-1:0] path_sens,
   output logic [DUTY_W-1:0] duty_l,
   output logic [DUTY_W-1:0] duty_r,
   output logic [1:0]        dir_l,
   output logic [1:0]        dir_r,
   output logic [N_SENS-1:0] led_dir,
   output logic              lost
);
   // state     | meaning
   // S_IDLE    | tracking disabled, full speed forward
   // S_TRACK   | decoding sensors every cycle
   // S_PIVOT_L | timed left pivot, sensors ignored
   // S_PIVOT_R | timed right pivot, sensors ignored
   // S_SEARCH  | line lost, spinning toward last known side
   // S_STOP    | search timed out, braked until disabled
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_TRACK   = 3'd1;
   localparam logic [2:0] S_PIVOT_L = 3'd2;
   localparam logic [2:0] S_PIVOT_R = 3'd3;
   localparam logic [2:0] S_SEARCH  = 3'd4;
   localparam logic [2:0] S_STOP    = 3'd5;

   localparam logic [1:0] DIR_FWD = 2'b01;
   localparam logic [1:0] DIR_REV = 2'b10;
   localparam logic [1:0] DIR_BRK = 2'b00;
   localparam logic       LAST_LEFT  = 1'b0;
   localparam logic       LAST_RIGHT = 1'b1;

   localparam int TURN_W = $clog2(TURN_HOLD + 1);
   localparam int LOST_W = $clog2(LOST_DLY + 1);
   localparam int SRCH_W = $clog2(SEARCH_MAX + 1);
   localparam int HALF   = N_SENS / 2;

   localparam logic [DUTY_W-1:0] D_FULL  = DUTY_W'(SPD_FULL);
   localparam logic [DUTY_W-1:0] D_SHARP = DUTY_W'(SPD_SHARP);
   localparam logic [DUTY_W-1:0] D_CURVE = DUTY_W'(SPD_CURVE);
   localparam logic [DUTY_W-1:0] D_EDGE  = DUTY_W'(SPD_EDGE);
   localparam logic [N_SENS-1:0] LED_L   = {{HALF{1'b1}}, {HALF{1'b0}}};
   localparam logic [N_SENS-1:0] LED_R   = {{HALF{1'b0}}, {HALF{1'b1}}};

   logic [2:0]        state;
   logic              last_dir;
   logic [TURN_W-1:0] turn_cnt;
   logic [LOST_W-1:0] lost_cnt;
   logic [SRCH_W-1:0] search_cnt;
   logic [N_SENS-1:0] sens_use;

`ifdef TRACK_SYNC_EN
   logic [N_SENS-1:0] sens_meta, sens_sync;
   always_ff @(posedge clk) begin
      if (rst) begin
         sens_meta <= '1;
         sens_sync <= '1;
      end else begin
         sens_meta <= path_sens;
         sens_sync <= sens_meta;
      end
   end
   assign sens_use = sens_sync;
`else
   assign sens_use = path_sens;
`endif

   logic [N_SENS-1:0] d;
   logic lh, rh, il, ir, any_det;
   assign d       = ~sens_use;
   assign lh      = |d[N_SENS-1:HALF];
   assign rh      = |d[HALF-1:0];
   assign il      = |d[N_SENS-2:HALF];
   assign ir      = |d[HALF-1:1];
   assign any_det = |d;

   logic [1:0] srch_dir_l, srch_dir_r;
   assign srch_dir_l = (last_dir == LAST_LEFT) ? DIR_REV : DIR_FWD;
   assign srch_dir_r = (last_dir == LAST_LEFT) ? DIR_FWD : DIR_REV;

   // One TRACK-rule evaluation, shared by TRACK and by the exits from PIVOT and SEARCH.
   logic [2:0]        trk_state;
   logic [DUTY_W-1:0] trk_duty_l, trk_duty_r;
   logic [1:0]        trk_dir_l, trk_dir_r;
   logic [N_SENS-1:0] trk_led;
   logic              trk_lost, trk_last;
   logic [TURN_W-1:0] trk_turn;
   logic [LOST_W-1:0] trk_lost_cnt;

   always_comb begin
      trk_state    = S_TRACK;
      trk_duty_l   = D_EDGE;
      trk_duty_r   = D_EDGE;
      trk_dir_l    = DIR_FWD;
      trk_dir_r    = DIR_FWD;
      trk_led      = d;
      trk_lost     = 1'b0;
      trk_last     = last_dir;
      trk_turn     = '0;
      trk_lost_cnt = '0;
      if (d[0] && lh) begin
         trk_state  = S_PIVOT_R;
         trk_duty_l = D_SHARP;
         trk_duty_r = D_SHARP;
         trk_dir_r  = DIR_REV;
         trk_led    = LED_R;
         trk_last   = LAST_RIGHT;
         trk_turn   = TURN_W'(TURN_HOLD - 1);
      end else if (d[N_SENS-1] && rh) begin
         trk_state  = S_PIVOT_L;
         trk_duty_l = D_SHARP;
         trk_duty_r = D_SHARP;
         trk_dir_l  = DIR_REV;
         trk_led    = LED_L;
         trk_last   = LAST_LEFT;
         trk_turn   = TURN_W'(TURN_HOLD - 1);
      end else if (d[N_SENS-1]) begin
         trk_dir_l = DIR_REV;
         trk_last  = LAST_LEFT;
      end else if (d[0]) begin
         trk_dir_r = DIR_REV;
         trk_last  = LAST_RIGHT;
      end else if (il && !ir) begin
         trk_duty_l = '0;
         trk_duty_r = D_CURVE;
         trk_last   = LAST_LEFT;
      end else if (ir && !il) begin
         trk_duty_l = D_CURVE;
         trk_duty_r = '0;
         trk_last   = LAST_RIGHT;
      end else if (il && ir) begin
         trk_duty_l = D_FULL;
         trk_duty_r = D_FULL;
      end else if (lost_cnt >= LOST_W'(LOST_DLY)) begin
         trk_state    = S_SEARCH;
         trk_dir_l    = srch_dir_l;
         trk_dir_r    = srch_dir_r;
         trk_led      = '1;
         trk_lost     = 1'b1;
         trk_lost_cnt = lost_cnt;
      end else begin
         trk_lost_cnt = lost_cnt + 1'b1;
      end
   end

   logic [2:0]        nxt_state;
   logic [DUTY_W-1:0] nxt_duty_l, nxt_duty_r;
   logic [1:0]        nxt_dir_l, nxt_dir_r;
   logic [N_SENS-1:0] nxt_led;
   logic              nxt_lost, nxt_last, take_trk;
   logic [TURN_W-1:0] nxt_turn;
   logic [LOST_W-1:0] nxt_lost_cnt;
   logic [SRCH_W-1:0] nxt_search_cnt, srch_step;

   always_comb begin
      nxt_state      = state;
      nxt_duty_l     = duty_l;
      nxt_duty_r     = duty_r;
      nxt_dir_l      = dir_l;
      nxt_dir_r      = dir_r;
      nxt_led        = led_dir;
      nxt_lost       = lost;
      nxt_last       = last_dir;
      nxt_turn       = turn_cnt;
      nxt_lost_cnt   = lost_cnt;
      nxt_search_cnt = search_cnt;
      take_trk       = 1'b0;
      srch_step      = (search_cnt >= SRCH_W'(SEARCH_MAX)) ? search_cnt : search_cnt + 1'b1;
      case (state)
         S_IDLE:    nxt_state = S_TRACK;
         S_TRACK:   take_trk = 1'b1;
         S_PIVOT_L, S_PIVOT_R: begin
            if (turn_cnt == '0) take_trk = 1'b1;
            else                nxt_turn = turn_cnt - 1'b1;
         end
         S_SEARCH: begin
            if (any_det) begin
               take_trk = 1'b1;
            end else if (srch_step >= SRCH_W'(SEARCH_MAX)) begin
               nxt_state      = S_STOP;
               nxt_search_cnt = srch_step;
               nxt_duty_l     = '0;
               nxt_duty_r     = '0;
               nxt_dir_l      = DIR_BRK;
               nxt_dir_r      = DIR_BRK;
               nxt_led        = '0;
               nxt_lost       = 1'b1;
            end else begin
               nxt_search_cnt = srch_step;
               nxt_duty_l     = D_EDGE;
               nxt_duty_r     = D_EDGE;
               nxt_dir_l      = srch_dir_l;
               nxt_dir_r      = srch_dir_r;
               nxt_led        = '1;
               nxt_lost       = 1'b1;
            end
         end
         S_STOP: ;
         default:   nxt_state = S_IDLE;
      endcase
      if (take_trk) begin
         nxt_state      = trk_state;
         nxt_duty_l     = trk_duty_l;
         nxt_duty_r     = trk_duty_r;
         nxt_dir_l      = trk_dir_l;
         nxt_dir_r      = trk_dir_r;
         nxt_led        = trk_led;
         nxt_lost       = trk_lost;
         nxt_last       = trk_last;
         nxt_turn       = trk_turn;
         nxt_lost_cnt   = trk_lost_cnt;
         nxt_search_cnt = '0;
      end
      if (!en_tracing || state == S_IDLE || state > S_STOP) begin
         nxt_state      = (en_tracing && state == S_IDLE) ? S_TRACK : S_IDLE;
         nxt_duty_l     = D_FULL;
         nxt_duty_r     = D_FULL;
         nxt_dir_l      = DIR_FWD;
         nxt_dir_r      = DIR_FWD;
         nxt_led        = '0;
         nxt_lost       = 1'b0;
         nxt_turn       = '0;
         nxt_lost_cnt   = '0;
         nxt_search_cnt = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         duty_l     <= '0;
         duty_r     <= '0;
         dir_l      <= DIR_BRK;
         dir_r      <= DIR_BRK;
         led_dir    <= '0;
         lost       <= 1'b0;
         last_dir   <= LAST_LEFT;
         turn_cnt   <= '0;
         lost_cnt   <= '0;
         search_cnt <= '0;
      end else begin
         state      <= nxt_state;
         duty_l     <= nxt_duty_l;
         duty_r     <= nxt_duty_r;
         dir_l      <= nxt_dir_l;
         dir_r      <= nxt_dir_r;
         led_dir    <= nxt_led;
         lost       <= nxt_lost;
         last_dir   <= nxt_last;
         turn_cnt   <= nxt_turn;
         lost_cnt   <= nxt_lost_cnt;
         search_cnt <= nxt_search_cnt;
      end
   end
endmodule

// File: tb/tb_line_track_steer.sv
// Directed bench for line_track_steer at default parameters (N_SENS=4, no synchroniser).
module tb_line_track_steer;
   logic       clk = 1'b0;
   logic       rst, en_tracing;
   logic [3:0] path_sens;
   logic [7:0] duty_l, duty_r;
   logic [1:0] dir_l, dir_r;
   logic [3:0] led_dir;
   logic       lost;

   int errors = 0;
   int checks = 0;
   int n;

   line_track_steer dut (
      .clk(clk), .rst(rst), .en_tracing(en_tracing), .path_sens(path_sens),
      .duty_l(duty_l), .duty_r(duty_r), .dir_l(dir_l), .dir_r(dir_r),
      .led_dir(led_dir), .lost(lost)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [3:0] ps;
      logic [7:0] el, er;
      logic [1:0] dl, dr;
      logic [3:0] led;
      logic       lst;
   } vec_t;

   vec_t vecs[9];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] el, input logic [7:0] er,
                      input logic [1:0] dl, input logic [1:0] dr,
                      input logic [3:0] led, input logic lst);
      checks++;
      if (duty_l !== el || duty_r !== er || dir_l !== dl || dir_r !== dr ||
          led_dir !== led || lost !== lst) begin
         errors++;
         $display("FAIL %s: got duty %0d/%0d dir %b/%b led %b lost %b, want duty %0d/%0d dir %b/%b led %b lost %b",
                  name, duty_l, duty_r, dir_l, dir_r, led_dir, lost, el, er, dl, dr, led, lst);
      end
   endtask

   task automatic chk_cnt(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d cycles, want %0d", name, got, want);
      end
   endtask

   function automatic bit out_is(input logic [7:0] el, input logic [7:0] er,
                                 input logic [1:0] dl, input logic [1:0] dr, input logic lst);
      return duty_l === el && duty_r === er && dir_l === dl && dir_r === dr && lost === lst;
   endfunction

   initial begin
      vecs[0] = '{"straight",    4'b1001, 8'd255, 8'd255, 2'b01, 2'b01, 4'b0110, 1'b0};
      vecs[1] = '{"curve_left",  4'b1011, 8'd0,   8'd220, 2'b01, 2'b01, 4'b0100, 1'b0};
      vecs[2] = '{"curve_right", 4'b1101, 8'd220, 8'd0,   2'b01, 2'b01, 4'b0010, 1'b0};
      vecs[3] = '{"spin_left",   4'b0111, 8'd150, 8'd150, 2'b10, 2'b01, 4'b1000, 1'b0};
      vecs[4] = '{"spin_right",  4'b1110, 8'd150, 8'd150, 2'b01, 2'b10, 4'b0001, 1'b0};
      vecs[5] = '{"spin_left2",  4'b0011, 8'd150, 8'd150, 2'b10, 2'b01, 4'b1100, 1'b0};
      vecs[6] = '{"spin_right2", 4'b1100, 8'd150, 8'd150, 2'b01, 2'b10, 4'b0011, 1'b0};
      vecs[7] = '{"creep",       4'b1111, 8'd150, 8'd150, 2'b01, 2'b01, 4'b0000, 1'b0};
      vecs[8] = '{"straight2",   4'b1001, 8'd255, 8'd255, 2'b01, 2'b01, 4'b0110, 1'b0};

      rst = 1'b1; en_tracing = 1'b0; path_sens = 4'b1111;
      step();
      chk("reset", 8'd0, 8'd0, 2'b00, 2'b00, 4'b0000, 1'b0);
      rst = 1'b0;
      step();
      chk("idle", 8'd255, 8'd255, 2'b01, 2'b01, 4'b0000, 1'b0);

      en_tracing = 1'b1; path_sens = 4'b1001;
      step();
      chk("idle_to_track", 8'd255, 8'd255, 2'b01, 2'b01, 4'b0000, 1'b0);
      step();
      chk("track_first", 8'd255, 8'd255, 2'b01, 2'b01, 4'b0110, 1'b0);

      for (int i = 0; i < 9; i++) begin
         path_sens = vecs[i].ps;
         step();
         chk(vecs[i].name, vecs[i].el, vecs[i].er, vecs[i].dl, vecs[i].dr, vecs[i].led, vecs[i].lst);
      end

      // Right pivot held for TURN_HOLD cycles regardless of sensors, then creep.
      path_sens = 4'b0110;
      step();
      chk("pivot_r_entry", 8'd250, 8'd250, 2'b01, 2'b10, 4'b0011, 1'b0);
      path_sens = 4'b1111;
      n = 0;
      while (out_is(8'd250, 8'd250, 2'b01, 2'b10, 1'b0) && n < 200) begin
         n++;
         step();
      end
      chk_cnt("pivot_r_len", n, 80);
      chk("pivot_r_exit", 8'd150, 8'd150, 2'b01, 2'b01, 4'b0000, 1'b0);

      // Left curve, then line lost: creep, search left, stop.
      path_sens = 4'b1011;
      step();
      chk("curve_left_pre", 8'd0, 8'd220, 2'b01, 2'b01, 4'b0100, 1'b0);
      path_sens = 4'b1111;
      step();
      n = 0;
      while (out_is(8'd150, 8'd150, 2'b01, 2'b01, 1'b0) && n < 100) begin
         n++;
         step();
      end
      chk_cnt("creep_len", n, 16);
      chk("search_left", 8'd150, 8'd150, 2'b10, 2'b01, 4'b1111, 1'b1);
      n = 0;
      while (out_is(8'd150, 8'd150, 2'b10, 2'b01, 1'b1) && n < 5000) begin
         n++;
         step();
      end
      chk_cnt("search_len", n, 4096);
      chk("stop", 8'd0, 8'd0, 2'b00, 2'b00, 4'b0000, 1'b1);
      path_sens = 4'b1001;
      step(); step();
      chk("stop_sticky", 8'd0, 8'd0, 2'b00, 2'b00, 4'b0000, 1'b1);

      en_tracing = 1'b0;
      step();
      chk("stop_to_idle", 8'd255, 8'd255, 2'b01, 2'b01, 4'b0000, 1'b0);

      // Disable mid left pivot, then re-enable.
      en_tracing = 1'b1; path_sens = 4'b0101;
      step();
      step();
      chk("pivot_l_entry", 8'd250, 8'd250, 2'b10, 2'b01, 4'b1100, 1'b0);
      for (int i = 0; i < 5; i++) step();
      chk("pivot_l_hold", 8'd250, 8'd250, 2'b10, 2'b01, 4'b1100, 1'b0);
      en_tracing = 1'b0;
      step();
      chk("pivot_l_disable", 8'd255, 8'd255, 2'b01, 2'b01, 4'b0000, 1'b0);
      en_tracing = 1'b1; path_sens = 4'b1001;
      step(); step();
      chk("reenable_track", 8'd255, 8'd255, 2'b01, 2'b01, 4'b0110, 1'b0);

      // Sharp pattern on the cycle the lost delay expires takes priority.
      path_sens = 4'b1111;
      for (int i = 0; i < 16; i++) step();
      chk("creep_16th", 8'd150, 8'd150, 2'b01, 2'b01, 4'b0000, 1'b0);
      path_sens = 4'b0110;
      step();
      chk("sharp_beats_lost", 8'd250, 8'd250, 2'b01, 2'b10, 4'b0011, 1'b0);

      // Reset mid-pivot.
      rst = 1'b1; path_sens = 4'b1111;
      step();
      chk("reset_mid_pivot", 8'd0, 8'd0, 2'b00, 2'b00, 4'b0000, 1'b0);
      rst = 1'b0;

      // Right curve, lose line, search right, recover on detect.
      path_sens = 4'b1101;
      step(); step();
      chk("curve_right_pre", 8'd220, 8'd0, 2'b01, 2'b01, 4'b0010, 1'b0);
      path_sens = 4'b1111;
      for (int i = 0; i < 17; i++) step();
      chk("search_right", 8'd150, 8'd150, 2'b01, 2'b10, 4'b1111, 1'b1);
      path_sens = 4'b1001;
      step();
      chk("search_recover", 8'd255, 8'd255, 2'b01, 2'b01, 4'b0110, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
